// File: rtl/sram_arbiter_if.sv
// Bundle between the two SRAM requesters, the arbiter and the external SRAM pins.
// The slave side is the arbiter; the master side is everything around it.
interface sram_arbiter_if;
  logic        req0;
  logic [19:0] addr0;
  logic        req1;
  logic [19:0] addr1;
  logic        we1;
  logic [15:0] wdata1;
  logic [1:0]  grant;
  logic [1:0]  done;
  logic [15:0] rdata;
  logic        busy;
  logic [19:0] sram_addr;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;

  modport slave (
    input  req0, addr0, req1, addr1, we1, wdata1, sram_dq_in,
    output grant, done, rdata, busy,
    output sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_out, sram_dq_oe
  );

  modport master (
    output req0, addr0, req1, addr1, we1, wdata1, sram_dq_in,
    input  grant, done, rdata, busy,
    input  sram_addr, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_out, sram_dq_oe
  );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter giving a background loader (reads only) and game logic
// (reads/writes) turns on a single asynchronous SRAM with fixed strobe width.
module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  sram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [3:0] COUNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  count_q, count_d;
  logic        last_q, last_d;     // 0 = requester 0 owned the last access
  logic        we_q, we_d;
  logic [19:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  done_q, done_d;
  logic [15:0] rdata_q, rdata_d;
  logic        winner;
  logic        in_access;

  // On a tie the requester that did not go last wins.
  always_comb begin
    winner = bus.req1;
    if (bus.req0 && bus.req1) begin
      winner = ~last_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= 20'd0;
      wdata_q <= 16'd0;
      grant_q <= 2'b00;
      done_q  <= 2'b00;
      rdata_q <= 16'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    grant_d = grant_q;
    done_d  = 2'b00;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d = ACCESS;
          count_d = COUNT_LOAD;
          last_d  = winner;
          // Requester 0 is read-only, so its we is forced low here.
          we_d    = winner & bus.we1;
          addr_d  = winner ? bus.addr1 : bus.addr0;
          wdata_d = bus.wdata1;
          grant_d = winner ? 2'b10 : 2'b01;
        end
      end
      ACCESS: begin
        if (count_q == 4'd0) begin
          state_d = DONE;
          done_d  = grant_q;
          if (!we_q) begin
            rdata_d = bus.sram_dq_in;
          end
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // Strobes decode straight from registered state so reset releases them at once.
  assign in_access       = (state_q == ACCESS);
  assign bus.sram_ce_n   = ~in_access;
  assign bus.sram_oe_n   = ~(in_access & ~we_q);
  assign bus.sram_we_n   = ~(in_access & we_q);
  assign bus.sram_dq_oe  = in_access & we_q;
  assign bus.sram_addr   = addr_q;
  assign bus.sram_dq_out = wdata_q;
  assign bus.grant       = grant_q;
  assign bus.done        = done_q;
  assign bus.rdata       = rdata_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed and randomized checks of sram_arbiter against a transaction-level
// model: round-robin winner order, strobe shape, done pulse and read data.
module tb_sram_arbiter;
  localparam int W = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_arbiter_if bus();

  sram_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Unwritten SRAM words hold a fill pattern derived from the address.
  function automatic logic [15:0] default_word(input logic [19:0] a);
    return 16'h1234 ^ {a[7:0], a[7:0]};
  endfunction

  // Behavioural SRAM: 256 words aliased over the address space.
  logic [15:0] sram_mem [256];
  bit   [255:0] sram_wr;
  always @(posedge clk) begin
    if (!bus.sram_ce_n && !bus.sram_we_n) begin
      sram_mem[bus.sram_addr[7:0]] <= bus.sram_dq_out;
      sram_wr[bus.sram_addr[7:0]]  <= 1'b1;
    end
  end
  assign bus.sram_dq_in = (!bus.sram_ce_n && !bus.sram_oe_n)
                          ? (sram_wr[bus.sram_addr[7:0]] ? sram_mem[bus.sram_addr[7:0]]
                                                         : default_word(bus.sram_addr))
                          : 16'hDEAD;

  // Reference model state.
  logic [15:0] model_mem [256];
  bit   [255:0] model_wr;
  int          last_owner;
  logic [15:0] exp_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("grant_onehot", 32'($countones(bus.grant) <= 1), 32'd1);
      chk("done_onehot",  32'($countones(bus.done) <= 1), 32'd1);
    end
  end

  // Called in IDLE just before the sampling edge; ends in the following IDLE cycle.
  task automatic expect_txn(input int owner, input logic we, input logic [19:0] addr,
                            input logic [15:0] wdata, input bit perturb);
    logic [1:0] g;
    logic [15:0] rd;
    g = (owner == 1) ? 2'b10 : 2'b01;
    @(posedge clk); #1;
    for (int k = 0; k < W; k++) begin
      chk("acc_grant", 32'(bus.grant), 32'(g));
      chk("acc_busy",  32'(bus.busy), 32'd1);
      chk("acc_ce_n",  32'(bus.sram_ce_n), 32'd0);
      chk("acc_addr",  32'(bus.sram_addr), 32'(addr));
      chk("acc_oe_n",  32'(bus.sram_oe_n), 32'(we));
      chk("acc_we_n",  32'(bus.sram_we_n), 32'(!we));
      chk("acc_dq_oe", 32'(bus.sram_dq_oe), 32'(we));
      if (we) chk("acc_dq_out", 32'(bus.sram_dq_out), 32'(wdata));
      chk("acc_done",  32'(bus.done), 32'd0);
      if (k == 0 && perturb) begin
        if (owner == 0) begin
          bus.req0  = 1'b0;
          bus.addr0 = 20'($urandom);
        end else begin
          bus.req1   = 1'b0;
          bus.addr1  = 20'($urandom);
          bus.we1    = ~bus.we1;
          bus.wdata1 = 16'($urandom);
        end
      end
      @(posedge clk); #1;
    end
    if (we) begin
      model_mem[addr[7:0]] = wdata;
      model_wr[addr[7:0]]  = 1'b1;
    end else begin
      exp_rdata = model_wr[addr[7:0]] ? model_mem[addr[7:0]] : default_word(addr);
    end
    last_owner = owner;
    rd = exp_rdata;
    chk("done_pulse", 32'(bus.done), 32'(g));
    chk("done_grant", 32'(bus.grant), 32'(g));
    chk("done_busy",  32'(bus.busy), 32'd1);
    chk("done_ce_n",  32'(bus.sram_ce_n), 32'd1);
    chk("done_oe_n",  32'(bus.sram_oe_n), 32'd1);
    chk("done_we_n",  32'(bus.sram_we_n), 32'd1);
    chk("done_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
    chk("done_rdata", 32'(bus.rdata), 32'(rd));
    @(posedge clk); #1;
    chk("idle_grant", 32'(bus.grant), 32'd0);
    chk("idle_done",  32'(bus.done), 32'd0);
    chk("idle_busy",  32'(bus.busy), 32'd0);
    $display("txn owner=%0d we=%0d addr=%05h wdata=%04h rdata=%04h perturb=%0d",
             owner, we, addr, wdata, bus.rdata, perturb);
  endtask

  bit          pend [2];
  logic [19:0] paddr [2];
  logic        pwe;
  logic [15:0] pwd;
  int          win;

  initial begin
    rst = 1'b1;
    bus.req0 = 1'b0; bus.addr0 = 20'd0;
    bus.req1 = 1'b0; bus.addr1 = 20'd0; bus.we1 = 1'b0; bus.wdata1 = 16'd0;
    last_owner = 1;
    exp_rdata  = 16'd0;
    #12;
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_done",  32'(bus.done), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_addr",  32'(bus.sram_addr), 32'd0);
    chk("rst_ce_n",  32'(bus.sram_ce_n), 32'd1);
    chk("rst_oe_n",  32'(bus.sram_oe_n), 32'd1);
    chk("rst_we_n",  32'(bus.sram_we_n), 32'd1);
    chk("rst_dq_out",32'(bus.sram_dq_out), 32'd0);
    chk("rst_dq_oe", 32'(bus.sram_dq_oe), 32'd0);

    // Both requesters held from reset: 01, 10, 01 alternation.
    bus.req0 = 1'b1; bus.addr0 = 20'h00006;
    bus.req1 = 1'b1; bus.addr1 = 20'h00006; bus.we1 = 1'b1; bus.wdata1 = 16'hCAFE;
    #8 rst = 1'b0;
    expect_txn(0, 1'b0, 20'h00006, 16'h0000, 1'b0);
    expect_txn(1, 1'b1, 20'h00006, 16'hCAFE, 1'b0);
    expect_txn(0, 1'b0, 20'h00006, 16'h0000, 1'b0);
    chk("rr_readback", 32'(bus.rdata), 32'h0000CAFE);
    bus.req0 = 1'b0; bus.req1 = 1'b0;

    // Single loader read.
    bus.req0 = 1'b1; bus.addr0 = 20'h4B000;
    expect_txn(0, 1'b0, 20'h4B000, 16'h0000, 1'b0);
    bus.req0 = 1'b0;
    chk("rd_4b000", 32'(bus.rdata), 32'h00001234);

    // Game-logic write leaves rdata alone.
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 20'h00010; bus.wdata1 = 16'hBEEF;
    expect_txn(1, 1'b1, 20'h00010, 16'hBEEF, 1'b0);
    bus.req1 = 1'b0;
    chk("wr_rdata_kept", 32'(bus.rdata), 32'h00001234);

    // Owner drops req and scrambles inputs during the first ACCESS cycle.
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 20'h00020;
    expect_txn(1, 1'b0, 20'h00020, 16'h0000, 1'b1);
    @(posedge clk); #1;
    chk("drop_no_retry", 32'(bus.busy), 32'd0);

    // Reset in the second ACCESS cycle aborts the read.
    bus.req0 = 1'b1; bus.addr0 = 20'h4B000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_pre_ce_n", 32'(bus.sram_ce_n), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("abort_ce_n",  32'(bus.sram_ce_n), 32'd1);
    chk("abort_oe_n",  32'(bus.sram_oe_n), 32'd1);
    chk("abort_busy",  32'(bus.busy), 32'd0);
    chk("abort_grant", 32'(bus.grant), 32'd0);
    chk("abort_rdata", 32'(bus.rdata), 32'd0);
    bus.req0 = 1'b0;
    #1 rst = 1'b0;
    last_owner = 1;
    exp_rdata  = 16'd0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'(bus.done), 32'd0);
      chk("abort_idle",    32'(bus.busy), 32'd0);
    end

    // Randomized traffic against the model.
    pend[0] = 1'b0; pend[1] = 1'b0;
    paddr[0] = 20'd0; paddr[1] = 20'd0;
    pwe = 1'b0; pwd = 16'd0;
    for (int it = 0; it < 80; it++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && $urandom_range(0, 2) != 0) begin
          pend[r]  = 1'b1;
          paddr[r] = {12'($urandom), 8'($urandom_range(0, 15))};
          if (r == 1) begin
            pwe = 1'($urandom_range(0, 1));
            pwd = 16'($urandom);
          end
        end
      end
      bus.req0 = pend[0]; bus.addr0 = paddr[0];
      bus.req1 = pend[1]; bus.addr1 = paddr[1]; bus.we1 = pwe; bus.wdata1 = pwd;
      if (!pend[0] && !pend[1]) begin
        @(posedge clk); #1;
        chk("rand_idle_busy",  32'(bus.busy), 32'd0);
        chk("rand_idle_grant", 32'(bus.grant), 32'd0);
      end else begin
        if (pend[0] && pend[1]) win = 1 - last_owner;
        else                    win = pend[0] ? 0 : 1;
        expect_txn(win, (win == 1) ? pwe : 1'b0, paddr[win], pwd,
                   $urandom_range(0, 3) == 0);
        pend[win] = 1'b0;
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: WAIT_CYCLES, default 2, number of Clk cycles the SRAM strobes are held per access (legal range 1-15).
REQ-002 Clk  input  1  system clock; all state changes on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 req0  input  1  background-loader read request; addr0 stable while high.
REQ-005 addr0  input  20  background-loader SRAM word address.
REQ-006 req1  input  1  game-logic request (read or write); addr1/we1/wdata1 stable while high.
REQ-007 addr1  input  20  game-logic SRAM word address.
REQ-008 we1  input  1  1 = write, 0 = read, for requester 1.
REQ-009 wdata1  input  16  game-logic write data.
REQ-010 grant  output  2  one-hot owner of current access (bit0 = requester 0); 2'b00 when no access is in progress.
REQ-011 done  output  2  one-cycle completion pulse, one bit per requester.
REQ-012 rdata  output  16  last read word; held until the next read completes.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 SRAM_ADDR  output  20  address driven to SRAM.
REQ-015 SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  output  1 each  active-low SRAM strobes.
REQ-016 SRAM_DQ_OUT  output  16  write data; SRAM_DQ_OE  output  1  enables the tristate driver.
REQ-017 SRAM_DQ_IN  input  16  SRAM read data.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS, DONE.
- IDLE: if any req is high, latch the winner, addr and we, load counter = WAIT_CYCLES-1, go to ACCESS; else stay.
- ACCESS: decrement the counter; when it is 0, go to DONE.
- DONE: go to IDLE unconditionally.
REQ-019 Arbitration SHALL be round-robin using last_grant. Single request: it wins. Both requests: the requester not equal to last_grant wins. last_grant SHALL update when ACCESS is entered.
REQ-020 grant SHALL be registered. It is valid from the first ACCESS cycle through the DONE cycle, and 2'b00 in IDLE.
REQ-021 In ACCESS: SRAM_CE_N = 0 and SRAM_ADDR = latched address.
- Read: SRAM_OE_N = 0, SRAM_WE_N = 1, SRAM_DQ_OE = 0.
- Write: SRAM_OE_N = 1, SRAM_WE_N = 0, SRAM_DQ_OE = 1, SRAM_DQ_OUT = latched wdata1.
REQ-022 On a read, rdata SHALL capture SRAM_DQ_IN on the final ACCESS cycle (counter = 0). A write SHALL leave rdata unchanged.
REQ-023 In DONE, done[owner] SHALL be 1 for exactly one cycle. All strobes SHALL be high and SRAM_DQ_OE = 0.
REQ-024 Latency: req sampled high in IDLE at edge N gives done at cycle N+WAIT_CYCLES+1. There is one IDLE bubble, so the minimum period between accesses is WAIT_CYCLES+2 cycles.
REQ-025 Deasserting the owner's req during ACCESS SHALL NOT abort the access; done still pulses. A req dropped before being sampled in IDLE is ignored.
REQ-026 Changes on addr, we or wdata after latching SHALL NOT affect the access in progress.
REQ-027 Requester 0 SHALL never cause a write (SRAM_WE_N stays 1 for its accesses).
REQ-028 grant and done SHALL never have more than one bit set.

Reset
REQ-029 While Reset is high, independent of Clk:
- state = IDLE, counter = 0, last_grant = 1 (requester 0 wins the first tie).
- grant = 0, done = 0, rdata = 0, busy = 0.
- SRAM_ADDR = 0, SRAM_CE_N = SRAM_OE_N = SRAM_WE_N = 1, SRAM_DQ_OUT = 0, SRAM_DQ_OE = 0.
REQ-030 Reset asserted mid-ACCESS SHALL abort the access immediately: strobes go high, no done pulse is issued, and rdata returns to 0.

Verification (WAIT_CYCLES = 2)
REQ-031 req0 = 1, addr0 = 20'h4B000, SRAM returns 16'h1234 -> grant = 01 for 3 cycles, SRAM_ADDR = 20'h4B000 with CE_N/OE_N low for 2 cycles, done = 01 at N+3, rdata = 16'h1234.
REQ-032 req1 = 1, we1 = 1, addr1 = 20'h00010, wdata1 = 16'hBEEF -> SRAM_WE_N low and SRAM_DQ_OE = 1 with DQ_OUT = 16'hBEEF for 2 cycles, done = 10, rdata unchanged.
REQ-033 req0 and req1 both held high for 12 cycles after reset -> grants alternate 01, 10, 01 with a 4-cycle period; each done pulse matches its grant.
REQ-034 req1 read to 20'h00020, req1 dropped during the first ACCESS cycle -> access completes and done = 10 still pulses.
REQ-035 Reset pulsed during the second ACCESS cycle of a req0 read -> CE_N = 1 asynchronously, no done pulse, rdata = 0, state IDLE.
